// File: rtl/sam_memory_responder.sv
// SAM CPU bus memory responder: word-organised 16-bit RAM behind a request/wait handshake.
// mem_wait is high for exactly LATENCY cycles per access, counting the cycle request is first seen.
module sam_memory_responder #(
  parameter int    ADDR_BITS = 8,
  parameter int    LATENCY   = 3,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        request,
  input  logic        rw,
  input  logic [15:0] data_in,
  output logic        mem_wait,
  output logic [15:0] data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] idx;
    logic                 rw;
    logic [15:0]          wdata;
  } req_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [15:0] mem [0:(2**ADDR_BITS)-1];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [15:0] data_out_q, data_out_d;
  req_t        acc;
  logic        do_acc;
  logic        mem_we;

  logic unused_addr;
  assign unused_addr = ^{address[15:ADDR_BITS+1], address[0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    data_out_d = data_out_q;
    do_acc     = 1'b0;
    acc        = req_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          req_d = '{idx: address[ADDR_BITS:1], rw: rw, wdata: data_in};
          // The IDLE cycle already counts as one wait cycle; LATENCY=1 completes here.
          if (LATENCY <= 1) begin
            do_acc  = 1'b1;
            acc     = req_d;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          do_acc  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!request) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (do_acc && acc.rw) data_out_d = mem[acc.idx];
  end

  assign mem_we = do_acc && !acc.rw && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      req_q      <= '0;
      data_out_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      data_out_q <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[acc.idx] <= acc.wdata;
  end

  assign mem_wait = !reset && ((state_q == IDLE && request) || state_q == BUSY);
  assign data_out = data_out_q;

endmodule

// File: tb/tb_sam_memory_responder.sv
// Directed bench for sam_memory_responder (ADDR_BITS=8, LATENCY=3).
module tb_sam_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        request;
  logic        rw;
  logic [15:0] data_in;
  logic        mem_wait;
  logic [15:0] data_out;

  int vectors = 0;
  int miscompares = 0;

  sam_memory_responder #(.ADDR_BITS(8), .LATENCY(3), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .address(address), .request(request),
    .rw(rw), .data_in(data_in), .mem_wait(mem_wait), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Raise request after an edge and count wait-high cycles; returns at the negedge where wait is low.
  task automatic do_access(input logic [15:0] a, input logic r, input logic [15:0] d, output int n);
    @(posedge clk); #1;
    address = a; rw = r; data_in = d; request = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_wait) break;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic release_req();
    request = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; request = 1'b1; rw = 1'b1; address = 16'h0; data_in = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mem_wait !== 1'b0) begin miscompares++; $display("FAIL reset_wait got %b want 0", mem_wait); end
    vectors++;
    if (data_out !== 16'h0000) begin miscompares++; $display("FAIL reset_data got %h want 0000", data_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_wait !== 1'b1) begin miscompares++; $display("FAIL post_reset_wait got %b want 1", mem_wait); end
    request = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int n;
    do_access(16'h0010, 1'b0, 16'h1234, n);
    vectors++;
    if (n !== 3) begin miscompares++; $display("FAIL write_latency got %0d want 3", n); end
    vectors++;
    if (data_out !== 16'h0000) begin miscompares++; $display("FAIL write_data_out got %h want 0000", data_out); end
    release_req();
    do_access(16'h0010, 1'b1, 16'h0000, n);
    vectors++;
    if (n !== 3) begin miscompares++; $display("FAIL read_latency got %0d want 3", n); end
    vectors++;
    if (data_out !== 16'h1234) begin miscompares++; $display("FAIL read_data got %h want 1234", data_out); end
    release_req();
    do_access(16'h0011, 1'b1, 16'h0000, n);
    vectors++;
    if (data_out !== 16'h1234) begin miscompares++; $display("FAIL read_odd_byte got %h want 1234", data_out); end
    release_req();
  endtask

  task automatic test_alias();
    int n;
    do_access(16'h0210, 1'b0, 16'hBEEF, n);
    release_req();
    do_access(16'h0010, 1'b1, 16'h0000, n);
    vectors++;
    if (data_out !== 16'hBEEF) begin miscompares++; $display("FAIL alias_read got %h want beef", data_out); end
    release_req();
  endtask

  task automatic test_hold_done();
    int n;
    do_access(16'h0040, 1'b0, 16'h7777, n);
    release_req();
    do_access(16'h0040, 1'b1, 16'h0000, n);
    // Flip to a write while request stays high; DONE must not retrigger.
    rw = 1'b0; data_in = 16'hDEAD; address = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (mem_wait !== 1'b0) begin miscompares++; $display("FAIL hold_wait[%0d] got %b want 0", i, mem_wait); end
      vectors++;
      if (data_out !== 16'h7777) begin miscompares++; $display("FAIL hold_data[%0d] got %h want 7777", i, data_out); end
    end
    release_req();
    @(negedge clk);
    vectors++;
    if (mem_wait !== 1'b0) begin miscompares++; $display("FAIL idle_wait got %b want 0", mem_wait); end
    do_access(16'h0010, 1'b1, 16'h0000, n);
    vectors++;
    if (n !== 3) begin miscompares++; $display("FAIL reaccept_latency got %0d want 3", n); end
    vectors++;
    if (data_out !== 16'hBEEF) begin miscompares++; $display("FAIL no_retrigger got %h want beef", data_out); end
    release_req();
  endtask

  task automatic test_reset_abort();
    int n;
    do_access(16'h0020, 1'b0, 16'h5555, n);
    release_req();
    address = 16'h0020; rw = 1'b0; data_in = 16'hAAAA; request = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_wait !== 1'b0) begin miscompares++; $display("FAIL abort_wait got %b want 0", mem_wait); end
    @(posedge clk); #1;
    reset = 1'b0; request = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_wait !== 1'b0) begin miscompares++; $display("FAIL abort_idle_wait got %b want 0", mem_wait); end
    vectors++;
    if (data_out !== 16'h0000) begin miscompares++; $display("FAIL abort_data_out got %h want 0000", data_out); end
    do_access(16'h0020, 1'b1, 16'h0000, n);
    vectors++;
    if (data_out !== 16'h5555) begin miscompares++; $display("FAIL abort_no_write got %h want 5555", data_out); end
    vectors++;
    if (n !== 3) begin miscompares++; $display("FAIL abort_reread_latency got %0d want 3", n); end
    release_req();
  endtask

  task automatic test_back_to_back();
    int n;
    do_access(16'h0030, 1'b0, 16'hC0DE, n);
    release_req();
    do_access(16'h0030, 1'b1, 16'h0000, n);
    vectors++;
    if (data_out !== 16'hC0DE) begin miscompares++; $display("FAIL raw_read got %h want c0de", data_out); end
    release_req();
    do_access(16'h0032, 1'b1, 16'h0000, n);
    vectors++;
    if (data_out === 16'hC0DE) begin miscompares++; $display("FAIL adjacent_word got %h want not c0de", data_out); end
    release_req();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_hold_done();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
